serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller for the mini-cpu datapath.
- Sequences one instance of the existing 1-bit full_adder over a WIDTH-bit operand pair, LSB first, one bit per clock.
- Owns the operand shift registers, the carry flop, the bit counter and the start/done handshake.
- Trades area for latency in place of a ripple array of WIDTH adders.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 36 +++
 rtl/serial_adder_ctrl_full_adder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int SERIAL_ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// Optional overflow flag present when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = serial_adder_pkg::SERIAL_ADDER_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b, carry_in,
    input  ready, busy, done, sum, carry_out, overflow
  );
  modport slave (
    input  start, a, b, carry_in,
    output ready, busy, done, sum, carry_out, overflow
  );
`else
  modport master (
    output start, a, b, carry_in,
    input  ready, busy, done, sum, carry_out
  );
  modport slave (
    input  start, a, b, carry_in,
    output ready, busy, done, sum, carry_out
  );
`endif
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Existing 1-bit full adder used by the serial adder controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder sequenced LSB first over WIDTH bits.
// Define SERIAL_ADDER_OVERFLOW_EN to add a signed-overflow output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   sh_a_reg;
  logic [WIDTH-1:0]   sh_b_reg;
  logic [WIDTH-2:0]   sh_s_reg;
  logic               cy_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic               ready_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH-1:0]   sh_s_next;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic               ov_reg;
`endif

  full_adder u_fa (
    .a    (sh_a_reg[0]),
    .b    (sh_b_reg[0]),
    .cin  (cy_reg),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  // The newest sum bit enters at the top; after the last bit this is the result.
  assign sh_s_next = {fa_sum, sh_s_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sh_a_reg  <= '0;
      sh_b_reg  <= '0;
      sh_s_reg  <= '0;
      cy_reg    <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ov_reg    <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            sh_a_reg  <= bus.a;
            sh_b_reg  <= bus.b;
            cy_reg    <= bus.carry_in;
            cnt_reg   <= '0;
            state_reg <= RUN;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        RUN: begin
          sh_a_reg <= sh_a_reg >> 1;
          sh_b_reg <= sh_b_reg >> 1;
          sh_s_reg <= sh_s_next[WIDTH-1:1];
          cy_reg   <= fa_cout;
          if (cnt_reg == LAST_BIT) begin
            sum_reg   <= sh_s_next;
            cout_reg  <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // Carry into the MSB differs from carry out of it.
            ov_reg    <= cy_reg ^ fa_cout;
`endif
            cnt_reg   <= '0;
            state_reg <= DONE;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.sum       = sum_reg;
  assign bus.carry_out = cout_reg;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.overflow  = ov_reg;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed corner cases plus random operands.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ov;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nops = 0;
  logic in_reset = 1'b1;
  exp_t sb[$];
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;
  logic         held_ov = 1'b0;

  serial_adder_ctrl_if #(.WIDTH(W)) sif ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int   n;
    int   full;
    int   sgn;
    int   acc;
    exp_t e;
    n = 0;
    while (!sif.ready && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, sif.ready}, 32'd1);
    if (!sif.ready) return;
    sif.start    = 1'b1;
    sif.a        = a;
    sif.b        = b;
    sif.carry_in = cin;
    acc  = cyc;
    full = int'(a) + int'(b) + int'(cin);
    sgn  = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ov   = (sgn > (2 ** (W - 1)) - 1) || (sgn < -(2 ** (W - 1)));
    e.acc  = acc;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    sif.start    = 1'b0;
    sif.a        = W'($urandom);
    sif.b        = W'($urandom);
    sif.carry_in = 1'($urandom);
  endtask

  // Monitor: expected busy window and done cycle follow from the accept cycle.
  always @(negedge clk) begin : mon
    logic eb;
    logic ed;
    exp_t e;
    if (!in_reset) begin
      eb = (sb.size() > 0) && (cyc > sb[0].acc) && (cyc <= sb[0].acc + W);
      ed = (sb.size() > 0) && (cyc == sb[0].acc + W + 1);
      chk("busy", {31'd0, sif.busy}, {31'd0, eb});
      chk("ready", {31'd0, sif.ready}, {31'd0, !eb});
      chk("done", {31'd0, sif.done}, {31'd0, ed});
      if (ed) begin
        e = sb.pop_front();
        chk("sum", {24'd0, sif.sum}, {24'd0, e.sum});
        chk("carry_out", {31'd0, sif.carry_out}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("overflow", {31'd0, sif.overflow}, {31'd0, e.ov});
`endif
        held_sum  = e.sum;
        held_cout = e.cout;
        held_ov   = e.ov;
        nops++;
        $display("op %0d: sum=%h cout=%b ov=%b at cycle %0d", nops, sif.sum, sif.carry_out, e.ov, cyc);
      end else begin
        chk("hold_sum", {24'd0, sif.sum}, {24'd0, held_sum});
        chk("hold_cout", {31'd0, sif.carry_out}, {31'd0, held_cout});
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("hold_ov", {31'd0, sif.overflow}, {31'd0, held_ov});
`endif
      end
    end
  end

  initial begin
    int n;
    sif.start    = 1'b0;
    sif.a        = '0;
    sif.b        = '0;
    sif.carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, sif.ready}, 32'd1);
    chk("rst_busy", {31'd0, sif.busy}, 32'd0);
    chk("rst_done", {31'd0, sif.done}, 32'd0);
    chk("rst_sum", {24'd0, sif.sum}, 32'd0);
    chk("rst_cout", {31'd0, sif.carry_out}, 32'd0);
    #2 rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);

    issue(8'h00, 8'h00, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'h7F, 8'h01, 1'b0);
    issue(8'h80, 8'h80, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    // The follow-on request must land in the DONE cycle, with no IDLE gap.
    n = 0;
    while (!sif.ready && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_in_done", {31'd0, sif.done}, 32'd1);
    issue(8'h12, 8'h34, 1'b0);

    // Start pulse with new operands mid-run must be ignored.
    issue(8'h3C, 8'h5A, 1'b0);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'hFF;
    sif.b     = 8'hFF;
    @(negedge clk);
    sif.start = 1'b0;

    // Reset during RUN discards the operation.
    issue(8'h11, 8'h22, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    in_reset  = 1'b1;
    sb.delete();
    held_sum  = '0;
    held_cout = 1'b0;
    held_ov   = 1'b0;
    #1;
    chk("midrst_sum", {24'd0, sif.sum}, 32'd0);
    chk("midrst_cout", {31'd0, sif.carry_out}, 32'd0);
    chk("midrst_busy", {31'd0, sif.busy}, 32'd0);
    chk("midrst_ready", {31'd0, sif.ready}, 32'd1);
    @(negedge clk);
    chk("midrst_done", {31'd0, sif.done}, 32'd0);
    #2 rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    issue(8'hA5, 8'h5A, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end

    n = 0;
    while (sb.size() > 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
